// File: rtl/float_kulisch_pkg.sv
// rtl/float_kulisch_pkg.sv - shared types and width helpers for the float-to-Kulisch path
package float_kulisch_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} stateT;

    typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} floatClassT;

    function automatic int accWidth(input int nonFrac, input int frac);
        return nonFrac + frac + 1;
    endfunction

    function automatic int expBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_kulisch_accumulate_if.sv
// rtl/float_kulisch_accumulate_if.sv - float input stream and Kulisch sum output bundle
interface float_kulisch_accumulate_if #(
    parameter int EXP   = 8,
    parameter int FRAC  = 23,
    parameter int ACC_W = 21
);
    logic             inValid;
    logic             inReady;
    logic             inSign;
    logic [EXP-1:0]   inExp;
    logic [FRAC-1:0]  inFrac;
    logic             flushReq;
    logic             outValid;
    logic             outReady;
    logic [ACC_W-1:0] outAcc;
    logic             outOverflow;
    logic             outInexact;
    logic             outNan;
    logic             outInf;

    modport master (
        output inValid, inSign, inExp, inFrac, flushReq, outReady,
        input  inReady, outValid, outAcc, outOverflow, outInexact, outNan, outInf
    );

    modport slave (
        input  inValid, inSign, inExp, inFrac, flushReq, outReady,
        output inReady, outValid, outAcc, outOverflow, outInexact, outNan, outInf
    );
endinterface

// File: rtl/float_kulisch_align.sv
// rtl/float_kulisch_align.sv - exact alignment of a significand into Kulisch fixed point
module float_kulisch_align
    import float_kulisch_pkg::*;
#(
    parameter int EXP          = 8,
    parameter int FRAC         = 23,
    parameter int ACC_NON_FRAC = 10,
    parameter int ACC_FRAC     = 10,
    localparam int ACC_W       = accWidth(ACC_NON_FRAC, ACC_FRAC),
    localparam int SH_W        = EXP + 2
) (
    input  logic                   sign,
    input  floatClassT             fclass,
    input  logic [FRAC:0]          signif,
    input  logic signed [SH_W-1:0] shift,
    output logic [ACC_W-1:0]       aligned,
    output logic                   inexact,
    output logic                   overflow
);
    localparam int MAG_W = ACC_W - 1;
    localparam int SIG_W = FRAC + 1;
    localparam int BW    = MAG_W + 2 * SIG_W;

    // Significand sits above a SIG_W-bit guard field so right shifts keep every dropped bit visible.
    logic [BW-1:0]    wide;
    logic [MAG_W-1:0] mag;
    int               sh;

    always_comb begin
        wide     = '0;
        mag      = '0;
        inexact  = 1'b0;
        overflow = 1'b0;
        aligned  = '0;
        sh       = int'(shift);
        if (fclass == NORMAL || fclass == DENORM) begin
            wide[SIG_W +: SIG_W] = signif;
            if (sh >= MAG_W) begin
                overflow = |signif;
                wide     = '0;
            end else if (sh >= 0) begin
                wide = wide << unsigned'(sh);
            end else if (-sh > SIG_W) begin
                inexact = |signif;
                wide    = '0;
            end else begin
                wide = wide >> unsigned'(-sh);
            end
            inexact  = inexact | (|wide[SIG_W-1:0]);
            overflow = overflow | (|wide[BW-1:SIG_W+MAG_W]);
            mag      = wide[SIG_W +: MAG_W];
            if (!overflow) begin
                aligned = sign ? -{1'b0, mag} : {1'b0, mag};
            end
        end
    end
endmodule

// File: rtl/float_kulisch_accumulate.sv
// rtl/float_kulisch_accumulate.sv - streaming float-to-Kulisch exact accumulator with flush
module float_kulisch_accumulate
    import float_kulisch_pkg::*;
#(
    parameter int EXP          = 8,
    parameter int FRAC         = 23,
    parameter int ACC_NON_FRAC = 10,
    parameter int ACC_FRAC     = 10
) (
    input logic clock,
    input logic reset,
    float_kulisch_accumulate_if.slave bus
);
    localparam int ACC_W = accWidth(ACC_NON_FRAC, ACC_FRAC);
    localparam int BIAS  = expBias(EXP);
    localparam int SH_W  = EXP + 2;

    stateT                   state;
    logic                    s1Valid, s1Sign;
    floatClassT              s1Class;
    logic [FRAC:0]           s1Signif;
    logic signed [SH_W-1:0]  s1Shift;
    logic                    s2Valid, s2Sign, s2Inexact, s2Ovf, s2Inf, s2Nan;
    logic [ACC_W-1:0]        s2Aligned;
    logic [ACC_W-1:0]        acc;
    logic                    ovfFlag, inexactFlag, nanFlag, infFlag, infSeen, infSign;

    logic                    expZero, expOnes, fracZero, accept;
    floatClassT              inClass;
    logic [EXP-1:0]          effExp;
    logic signed [SH_W-1:0]  inShift;
    logic [ACC_W-1:0]        alignOut, sum;
    logic                    alignInexact, alignOvf, addOvf;

    assign expZero  = ~|bus.inExp;
    assign expOnes  = &bus.inExp;
    assign fracZero = ~|bus.inFrac;
    assign accept   = bus.inValid && bus.inReady;
    assign effExp   = expZero ? EXP'(1) : bus.inExp;
    assign inShift  = SH_W'(int'(effExp) - BIAS + ACC_FRAC - FRAC);

    always_comb begin
        inClass = NORMAL;
        if (expZero) inClass = fracZero ? ZERO : DENORM;
        else if (expOnes) inClass = fracZero ? INF : NAN;
    end

    float_kulisch_align #(
        .EXP(EXP), .FRAC(FRAC), .ACC_NON_FRAC(ACC_NON_FRAC), .ACC_FRAC(ACC_FRAC)
    ) align (
        .sign(s1Sign), .fclass(s1Class), .signif(s1Signif), .shift(s1Shift),
        .aligned(alignOut), .inexact(alignInexact), .overflow(alignOvf)
    );

    assign sum    = acc + s2Aligned;
    assign addOvf = (acc[ACC_W-1] == s2Aligned[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    assign bus.outAcc      = acc;
    assign bus.outOverflow = ovfFlag;
    assign bus.outInexact  = inexactFlag;
    assign bus.outNan      = nanFlag;
    assign bus.outInf      = infFlag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ACCUM;
            bus.inReady  <= 1'b1;
            bus.outValid <= 1'b0;
            s1Valid      <= 1'b0;
            s1Sign       <= 1'b0;
            s1Class      <= ZERO;
            s1Signif     <= '0;
            s1Shift      <= '0;
            s2Valid      <= 1'b0;
            s2Sign       <= 1'b0;
            s2Inexact    <= 1'b0;
            s2Ovf        <= 1'b0;
            s2Inf        <= 1'b0;
            s2Nan        <= 1'b0;
            s2Aligned    <= '0;
            acc          <= '0;
            ovfFlag      <= 1'b0;
            inexactFlag  <= 1'b0;
            nanFlag      <= 1'b0;
            infFlag      <= 1'b0;
            infSeen      <= 1'b0;
            infSign      <= 1'b0;
        end else begin
            s1Valid  <= accept;
            s1Sign   <= bus.inSign;
            s1Class  <= inClass;
            s1Signif <= {~expZero, bus.inFrac};
            s1Shift  <= inShift;

            s2Valid   <= s1Valid;
            s2Sign    <= s1Sign;
            s2Aligned <= alignOut;
            s2Inexact <= alignInexact;
            s2Ovf     <= alignOvf;
            s2Inf     <= s1Class == INF;
            s2Nan     <= s1Class == NAN;

            if (s2Valid) begin
                acc <= sum;
                if (s2Ovf || addOvf) ovfFlag <= 1'b1;
                if (s2Inexact) inexactFlag <= 1'b1;
                if (s2Nan) nanFlag <= 1'b1;
                if (s2Inf) begin
                    infFlag <= 1'b1;
                    infSeen <= 1'b1;
                    infSign <= s2Sign;
                    if (infSeen && infSign != s2Sign) nanFlag <= 1'b1;
                end
            end

            case (state)
                ACCUM: if (bus.flushReq) begin
                    state       <= DRAIN;
                    bus.inReady <= 1'b0;
                end
                // Once S1 is empty, whatever is in S2 lands in acc on this same edge.
                DRAIN: if (!s1Valid) begin
                    state        <= OUTPUT;
                    bus.outValid <= 1'b1;
                end
                OUTPUT: if (bus.outReady) begin
                    state        <= ACCUM;
                    bus.outValid <= 1'b0;
                    bus.inReady  <= 1'b1;
                    acc          <= '0;
                    ovfFlag      <= 1'b0;
                    inexactFlag  <= 1'b0;
                    nanFlag      <= 1'b0;
                    infFlag      <= 1'b0;
                    infSeen      <= 1'b0;
                    infSign      <= 1'b0;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: doc/float_kulisch_accumulate.md
Name: float_kulisch_accumulate

Overview:
- Streaming float-to-Kulisch converter and accumulator; the producer-side counterpart of the Kulisch-to-float conversion path.
- Accepts IEEE-style floats through a valid/ready handshake, aligns each exactly into a fixed-point Kulisch register and sums them without intermediate rounding.
- On request, it drains the pipeline and presents the exact sum, with sticky flags, downstream for float conversion.
- Sits between float producers (multiply/add units) and the Kulisch-to-float stage.

Parameters:
- EXP, 8, float exponent width; bias = 2^(EXP-1)-1.
- FRAC, 23, float fraction width (hidden bit implicit).
- ACC_NON_FRAC, 10, Kulisch integer bits (excluding sign).
- ACC_FRAC, 10, Kulisch fractional bits.
- Derived ACC_W = ACC_NON_FRAC+ACC_FRAC+1; the accumulator is two's complement.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  input float valid.
- inReady  out  1  block accepts input this cycle.
- inSign  in  1  float sign.
- inExp  in  EXP  float biased exponent.
- inFrac  in  FRAC  float fraction.
- flushReq  in  1  single-cycle request to present the sum.
- outValid  out  1  sum valid.
- outReady  in  1  downstream accepts the sum.
- outAcc  out  ACC_W  two's-complement Kulisch sum.
- outOverflow  out  1  sticky: an input or running sum exceeded range.
- outInexact  out  1  sticky: nonzero bits below the accumulator LSB were dropped.
- outNan  out  1  sticky: NaN input, or +inf and -inf both seen.
- outInf  out  1  sticky: an infinity was seen (sign held in outAcc MSB is invalid when set).

Behaviour:
- Reset (async assert, sync release):
  - all pipeline valids 0, accumulator 0, all flags 0.
  - state ACCUM, inReady=1, outValid=0.
- Pipeline, three stages; an input accepted at cycle t updates the accumulator at the edge ending cycle t+2:
  - S1 (decode): classify zero/denormal/normal/inf/nan. Denormal uses exponent 1 with hidden bit 0. Shift amount = exp - bias + ACC_FRAC - FRAC, signed.
  - S2 (align): significand (FRAC+1 bits) is shifted left, or right for a negative amount.
    - Any 1 bit shifted below the LSB sets the inexact flag.
    - A magnitude that does not fit in ACC_NON_FRAC+ACC_FRAC bits sets overflow; the value then contributes 0.
    - Negative sign: two's-complement negate to ACC_W bits.
  - S3 (accumulate): acc <= acc + aligned.
    - Signed overflow of the add sets overflow; the result wraps.
- Special inputs:
  - Zero: contributes nothing.
  - Inf: sets outInf, contributes 0. If an inf of the opposite sign was already seen, also sets outNan (an internal inf-sign register is kept).
  - NaN: sets outNan, contributes 0.
- State machine:
  - ACCUM: inReady=1. If flushReq is seen, go to DRAIN; an input presented in the same cycle is accepted and included in the sum.
  - DRAIN: inReady=0. Wait until S1..S3 are empty (at most 2 cycles), then go to OUTPUT.
  - OUTPUT: outValid=1; outAcc and the flags are stable and equal to the register values. On outValid && outReady: accumulator and flags clear to 0, return to ACCUM; inReady=1 the next cycle.
  - flushReq in DRAIN/OUTPUT: ignored.
- The inputs are ignored while inReady=0, regardless of inValid.
- Reset asserted mid-DRAIN/OUTPUT: immediate return to the reset state; the pending sum is discarded.

Decomposition:
- Package float_kulisch_pkg:
  - state enum {ACCUM, DRAIN, OUTPUT}.
  - float-class enum {ZERO, DENORM, NORMAL, INF, NAN}.
  - ACC_W / bias helper functions.
- Sub-module float_kulisch_align: combinational S2 shift/negate/inexact/overflow logic, parameterised identically, so the Kulisch-to-float side can share tests.

Test Plan (EXP=8, FRAC=23, ACC_NON_FRAC=10, ACC_FRAC=10, ACC_W=21):
- Inputs 0x3F800000, 0x40000000, 0xBF000000 back-to-back, then flushReq -> outValid 3 cycles after the last input; outAcc=2560 (0x000A00); all flags 0.
- Input 0x44800000 (1024.0) -> outOverflow=1, outAcc=0. Separately, 1023.0 (0x447FC000) twice -> add wraps, outOverflow=1.
- Input 0x3A000000 (2^-11) -> outAcc=0, outInexact=1. Input 0x3A800000 (2^-10) -> outAcc=1, outInexact=0.
- Input 0x7F800000 then 0xFF800000 -> outInf=1, outNan=1. Input 0x7FC00000 alone -> outNan=1, outInf=0.
- flushReq with inValid 0x3F800000 in the same cycle, outReady held low 5 cycles -> outValid held with outAcc=1024 and inReady=0. On the outReady handshake the accumulator clears; a subsequent 1.0+flush yields 1024.
- reset low while in OUTPUT -> outValid=0 and inReady=1 after release; a new flush with no inputs gives outAcc=0 and flags 0.
